// File: rtl/rp8_bd_pkg.sv
// rp8 data-bus RAM shared constants.
// Latency/wait-state limits and wait FSM encodings.
package rp8_bd_pkg;

  localparam int LAT_MAX = 4;
  localparam int WS_MAX  = 15;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

endpackage

// File: rtl/rp8_bd_pipe.sv
// Read-return delay line: LAT stages of {vld, id, data}.
// Payload only moves with a valid, so the tail holds the last return.
module rp8_bd_pipe #(
  parameter int IDW = 6,
  parameter int DW  = 8,
  parameter int LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_vld,
  input  logic [IDW-1:0] i_id,
  input  logic [DW-1:0]  i_data,
  output logic           o_vld,
  output logic [IDW-1:0] o_id,
  output logic [DW-1:0]  o_data
);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
  } stage_t;

  stage_t r_stg [LAT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        r_stg[i] <= '0;
      end
    end else begin
      r_stg[0].vld <= i_vld;
      if (i_vld) begin
        r_stg[0].id   <= i_id;
        r_stg[0].data <= i_data;
      end
      for (int i = 1; i < LAT; i++) begin
        r_stg[i].vld <= r_stg[i-1].vld;
        if (r_stg[i-1].vld) begin
          r_stg[i].id   <= r_stg[i-1].id;
          r_stg[i].data <= r_stg[i-1].data;
        end
      end
    end
  end

  assign o_vld  = r_stg[LAT-1].vld;
  assign o_id   = r_stg[LAT-1].id;
  assign o_data = r_stg[LAT-1].data;

endmodule

// File: rtl/rp8_bd_ram.sv
// rp8 data-bus RAM slave: masked writes, sized array,
// wait-state back-pressure and configurable read latency.
module rp8_bd_ram
  import rp8_bd_pkg::*;
#(
  parameter int DAW = 13,
  parameter int DW  = 8,
  parameter int IDW = 6,
  parameter int SZ  = 2**DAW,
  parameter int LAT = 1,
  parameter int WS  = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           bd_req,
  input  logic           bd_wen,
  input  logic [DAW-1:0] bd_adr,
  input  logic [IDW-1:0] bd_wid,
  input  logic [DW-1:0]  bd_wdt,
  input  logic [DW-1:0]  bd_msk,
  output logic           bd_ack,
  output logic [DW-1:0]  bd_rdt,
  output logic [IDW-1:0] bd_rid,
  output logic           bd_ren
);

  if (LAT < 1 || LAT > LAT_MAX) begin : g_bad_lat
    $error("rp8_bd_ram: LAT out of range");
  end
  if (WS < 0 || WS > WS_MAX) begin : g_bad_ws
    $error("rp8_bd_ram: WS out of range");
  end
  if (SZ < 1 || SZ > 2**DAW) begin : g_bad_sz
    $error("rp8_bd_ram: SZ out of range");
  end

  logic [DW-1:0] r_mem [SZ];

  logic          w_acc;
  logic          w_inr;
  logic [DW-1:0] w_rd;

  assign w_acc = bd_req & bd_ack;
  assign w_inr = 32'(bd_adr) < 32'(SZ);
  assign w_rd  = w_inr ? r_mem[bd_adr] : '0;

  if (WS == 0) begin : g_nows
    assign bd_ack = rst_n;
  end else begin : g_ws
    localparam logic [3:0] WSV = 4'(WS);

    logic [0:0] r_st;
    logic [3:0] r_wcnt;

    assign bd_ack = rst_n & bd_req & (r_wcnt == WSV);

    // a dropped request restarts the wait count
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_st   <= S_IDLE;
        r_wcnt <= '0;
      end else if (!bd_req || bd_ack) begin
        r_st   <= S_IDLE;
        r_wcnt <= '0;
      end else begin
        unique case (r_st)
          S_IDLE: begin
            r_st   <= S_WAIT;
            r_wcnt <= 4'd1;
          end
          default: r_wcnt <= r_wcnt + 4'd1;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc && bd_wen && w_inr) begin
      r_mem[bd_adr] <= (bd_wdt & bd_msk) | (r_mem[bd_adr] & ~bd_msk);
    end
  end

  rp8_bd_pipe #(
    .IDW (IDW),
    .DW  (DW),
    .LAT (LAT)
  ) u_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_vld  (w_acc & ~bd_wen),
    .i_id   (bd_wid),
    .i_data (w_rd),
    .o_vld  (bd_ren),
    .o_id   (bd_rid),
    .o_data (bd_rdt)
  );

endmodule

// File: tb/tb_rp8_bd_ram.sv
// Directed bench for rp8_bd_ram across four latency/wait/size
// configurations sharing one clock and reset.
module tb_rp8_bd_ram;

  localparam int DAW = 13;
  localparam int DW  = 8;
  localparam int IDW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           req [4];
  logic           wen [4];
  logic [DAW-1:0] adr [4];
  logic [IDW-1:0] wid [4];
  logic [DW-1:0]  wdt [4];
  logic [DW-1:0]  msk [4];
  logic           ack [4];
  logic           ren [4];
  logic [DW-1:0]  rdt [4];
  logic [IDW-1:0] rid [4];

  int n_vec = 0;
  int n_err = 0;
  int wt;

  // 0: LAT1 WS0 SZ100, 1: LAT3, 2: WS2, 3: LAT4
  rp8_bd_ram #(.DAW(DAW), .DW(DW), .IDW(IDW), .SZ(100), .LAT(1), .WS(0)) u_a (
    .clk(clk), .rst_n(rst_n), .bd_req(req[0]), .bd_wen(wen[0]),
    .bd_adr(adr[0]), .bd_wid(wid[0]), .bd_wdt(wdt[0]), .bd_msk(msk[0]),
    .bd_ack(ack[0]), .bd_rdt(rdt[0]), .bd_rid(rid[0]), .bd_ren(ren[0]));

  rp8_bd_ram #(.DAW(DAW), .DW(DW), .IDW(IDW), .LAT(3), .WS(0)) u_b (
    .clk(clk), .rst_n(rst_n), .bd_req(req[1]), .bd_wen(wen[1]),
    .bd_adr(adr[1]), .bd_wid(wid[1]), .bd_wdt(wdt[1]), .bd_msk(msk[1]),
    .bd_ack(ack[1]), .bd_rdt(rdt[1]), .bd_rid(rid[1]), .bd_ren(ren[1]));

  rp8_bd_ram #(.DAW(DAW), .DW(DW), .IDW(IDW), .LAT(1), .WS(2)) u_c (
    .clk(clk), .rst_n(rst_n), .bd_req(req[2]), .bd_wen(wen[2]),
    .bd_adr(adr[2]), .bd_wid(wid[2]), .bd_wdt(wdt[2]), .bd_msk(msk[2]),
    .bd_ack(ack[2]), .bd_rdt(rdt[2]), .bd_rid(rid[2]), .bd_ren(ren[2]));

  rp8_bd_ram #(.DAW(DAW), .DW(DW), .IDW(IDW), .LAT(4), .WS(0)) u_d (
    .clk(clk), .rst_n(rst_n), .bd_req(req[3]), .bd_wen(wen[3]),
    .bd_adr(adr[3]), .bd_wid(wid[3]), .bd_wdt(wdt[3]), .bd_msk(msk[3]),
    .bd_ack(ack[3]), .bd_rdt(rdt[3]), .bd_rid(rid[3]), .bd_ren(ren[3]));

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic resync();
    @(posedge clk);
    #1;
  endtask

  // called at posedge+1, returns at accepting edge+1
  task automatic acc(input int k, input logic w, input logic [DAW-1:0] a,
                     input logic [IDW-1:0] id, input logic [DW-1:0] d,
                     input logic [DW-1:0] m, output int waits);
    waits = 0;
    req[k] = 1'b1;
    wen[k] = w;
    adr[k] = a;
    wid[k] = id;
    wdt[k] = d;
    msk[k] = m;
    forever begin
      @(negedge clk);
      if (ack[k]) break;
      waits++;
      if (waits > 20) begin
        n_vec++;
        n_err++;
        $display("FAIL ack_timeout: got no ack on port %0d", k);
        break;
      end
    end
    @(posedge clk);
    #1;
    req[k] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      req[i] = 1'b0;
      wen[i] = 1'b0;
      adr[i] = '0;
      wid[i] = '0;
      wdt[i] = '0;
      msk[i] = '0;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", ack[0], 0);
    chk("rst_ren", ren[0], 0);
    chk("rst_rdt", rdt[0], 0);
    chk("rst_rid", rid[0], 0);
    chk("rst_ack_ws", ack[2], 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ack_ws0_idle", ack[0], 1);
    chk("ack_ws2_idle", ack[2], 0);
    resync();

    acc(0, 1'b1, 13'h010, 6'h00, 8'hA5, 8'hFF, wt);
    acc(0, 1'b0, 13'h010, 6'h2A, 8'h00, 8'h00, wt);
    @(negedge clk);
    chk("l1_ren", ren[0], 1);
    chk("l1_rdt", rdt[0], 8'hA5);
    chk("l1_rid", rid[0], 6'h2A);
    resync();
    @(negedge clk);
    chk("l1_ren_off", ren[0], 0);
    chk("l1_rdt_hold", rdt[0], 8'hA5);
    resync();

    acc(0, 1'b1, 13'h020, 6'h00, 8'hF0, 8'hFF, wt);
    acc(0, 1'b1, 13'h020, 6'h00, 8'h0F, 8'h3C, wt);
    acc(0, 1'b0, 13'h020, 6'h03, 8'h00, 8'h00, wt);
    @(negedge clk);
    chk("msk_rdt", rdt[0], 8'hCC);
    resync();
    acc(0, 1'b1, 13'h020, 6'h00, 8'hFF, 8'h00, wt);
    acc(0, 1'b0, 13'h020, 6'h04, 8'h00, 8'h00, wt);
    @(negedge clk);
    chk("msk0_rdt", rdt[0], 8'hCC);
    resync();

    acc(0, 1'b1, 13'd100, 6'h00, 8'h55, 8'hFF, wt);
    acc(0, 1'b0, 13'd100, 6'h05, 8'h00, 8'h00, wt);
    @(negedge clk);
    chk("oor_ren", ren[0], 1);
    chk("oor_rdt", rdt[0], 8'h00);
    chk("oor_rid", rid[0], 6'h05);
    resync();
    acc(0, 1'b1, 13'd99, 6'h00, 8'h77, 8'hFF, wt);
    acc(0, 1'b0, 13'd99, 6'h06, 8'h00, 8'h00, wt);
    @(negedge clk);
    chk("top_rdt", rdt[0], 8'h77);
    chk("top_ren", ren[0], 1);
    resync();

    for (int i = 1; i <= 4; i++) begin
      acc(1, 1'b1, 13'(i), 6'h00, 8'(8'h11 * i), 8'hFF, wt);
    end
    req[1] = 1'b1;
    wen[1] = 1'b0;
    adr[1] = 13'd1;
    wid[1] = 6'd1;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk);
      #1;
      if (c < 3) begin
        adr[1] = 13'(c + 2);
        wid[1] = 6'(c + 2);
      end else begin
        req[1] = 1'b0;
      end
      @(negedge clk);
      if (c >= 2 && c <= 5) begin
        chk("b_ren", ren[1], 1);
        chk("b_rid", rid[1], 32'(c - 1));
        chk("b_rdt", rdt[1], 32'(8'h11 * (c - 1)));
      end else begin
        chk("b_ren_off", ren[1], 0);
      end
    end
    resync();

    acc(2, 1'b1, 13'h005, 6'h00, 8'h3C, 8'hFF, wt);
    chk("ws_wr_waits", 32'(wt), 2);
    acc(2, 1'b0, 13'h005, 6'h07, 8'h00, 8'h00, wt);
    chk("ws_rd_waits", 32'(wt), 2);
    @(negedge clk);
    chk("ws_ren", ren[2], 1);
    chk("ws_rdt", rdt[2], 8'h3C);
    chk("ws_rid", rid[2], 6'h07);
    resync();

    acc(3, 1'b1, 13'h007, 6'h00, 8'h99, 8'hFF, wt);
    acc(3, 1'b0, 13'h007, 6'h11, 8'h00, 8'h00, wt);
    resync();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rs_ack", ack[3], 0);
    chk("rs_ren", ren[3], 0);
    resync();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rs_no_ren", ren[3], 0);
    end
    chk("rs_rdt0", rdt[0], 0);
    chk("rs_rid0", rid[0], 0);
    chk("rs_rid3", rid[3], 0);
    chk("rs_ack_after", ack[3], 1);
    resync();
    acc(3, 1'b0, 13'h007, 6'h12, 8'h00, 8'h00, wt);
    @(negedge clk);
    chk("l4_early", ren[3], 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("l4_ren", ren[3], 1);
    chk("l4_rdt", rdt[3], 8'h99);
    chk("l4_rid", rid[3], 6'h12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
